// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and defaults for the gcd request sequencer
package gcd_pkg;
    localparam int GCD_W       = 32;
    localparam int GCD_DEPTH   = 4;
    localparam int GCD_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } gcd_state_t;

    typedef struct packed {
        logic [GCD_W-1:0] a;
        logic [GCD_W-1:0] b;
    } gcd_pair_t;
endpackage

// File: rtl/gcd_op_fifo.sv
// rtl/gcd_op_fifo.sv - synchronous FIFO of operand pairs
module gcd_op_fifo
    import gcd_pkg::*;
#(
    parameter type T     = gcd_pair_t,
    parameter int  DEPTH = GCD_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         wdata,
    input  logic                     pop,
    output T                         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/gcd_req_sequencer.sv
// rtl/gcd_req_sequencer.sv - buffers operand pairs and issues them one at a time to a gcd engine
module gcd_req_sequencer
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int DEPTH   = GCD_DEPTH,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [W-1:0]             in_a_i,
    input  logic [W-1:0]             in_b_i,
    output logic                     start_o,
    output logic [W-1:0]             a_o,
    output logic [W-1:0]             b_o,
    input  logic                     busy_i,
    input  logic                     valid_i,
    input  logic [W-1:0]             result_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [W-1:0]             res_data_o,
    output logic                     res_err_o,
    output logic [$clog2(DEPTH):0]   pending_o
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    gcd_state_t    state;
    gcd_state_t    state_nxt;
    pair_t         wdata;
    pair_t         head;
    logic          full;
    logic          empty;
    logic          pop;
    logic [CW-1:0] wait_cnt;

    assign wdata       = {in_a_i, in_b_i};
    assign in_ready_o  = !full;
    assign pop         = (state == IDLE) && !empty;
    assign res_valid_o = (state == OUT);

    gcd_op_fifo #(
        .T     (pair_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (in_valid_i && in_ready_o),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (pending_o)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = ISSUE;
            ISSUE:   if (!busy_i) state_nxt = WAIT;
            WAIT:    if (valid_i || wait_cnt == LAST) state_nxt = OUT;
            OUT:     if (res_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A late result still beats the timeout when both land on the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            start_o    <= 1'b0;
            a_o        <= '0;
            b_o        <= '0;
            res_data_o <= '0;
            res_err_o  <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_o <= (state == ISSUE) && !busy_i;
            if (pop) begin
                a_o <= head.a;
                b_o <= head.b;
            end
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == WAIT) begin
                if (valid_i) begin
                    res_data_o <= result_i;
                    res_err_o  <= 1'b0;
                end else if (wait_cnt == LAST) begin
                    res_data_o <= '0;
                    res_err_o  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gcd_req_sequencer.sv
// tb/tb_gcd_req_sequencer.sv - self-checking bench for gcd_req_sequencer
module tb_gcd_req_sequencer;
    localparam int W  = 32;
    localparam int DP = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [W-1:0]  in_a_i;
    logic [W-1:0]  in_b_i;
    logic          start_o;
    logic [W-1:0]  a_o;
    logic [W-1:0]  b_o;
    logic          busy_i;
    logic          valid_i;
    logic [W-1:0]  result_i;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [W-1:0]  res_data_o;
    logic          res_err_o;
    logic [2:0]    pending_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int eng_delay = 0;
    bit eng_mute = 1'b0;

    gcd_req_sequencer #(.W(W), .DEPTH(DP), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i), .start_o(start_o), .a_o(a_o), .b_o(b_o),
        .busy_i(busy_i), .valid_i(valid_i), .result_i(result_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_err_o(res_err_o), .pending_o(pending_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          delay;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    function automatic logic [31:0] ref_gcd(logic [31:0] x, logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Engine model: answers each start with gcd(a,b) after eng_delay cycles.
    initial begin
        logic [31:0] ea;
        logic [31:0] eb;
        valid_i  = 1'b0;
        result_i = '0;
        forever begin
            tick();
            valid_i = 1'b0;
            if (start_o && !eng_mute) begin
                ea = a_o;
                eb = b_o;
                repeat (eng_delay) tick();
                result_i = ref_gcd(ea, eb);
                valid_i  = 1'b1;
            end
        end
    end

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int delay,
                           input logic [31:0] exp_data, input logic exp_err, input string tag);
        int push_cyc;
        int s;
        int n;
        int exp_lat;
        exp_lat = (delay <= TO - 1) ? delay + 1 : TO;
        eng_delay = delay;
        in_a_i = a;
        in_b_i = b;
        in_valid_i = 1'b1;
        tick();
        push_cyc = cyc;
        in_valid_i = 1'b0;
        n = 0;
        while (!start_o && n < 40) begin
            tick();
            n++;
        end
        check({tag, " start"}, 32'(start_o), 32'd1);
        check({tag, " start_lat"}, cyc - push_cyc, 32'd2);
        s = cyc;
        n = 0;
        while (!res_valid_o && n < 40) begin
            tick();
            n++;
        end
        check({tag, " res_valid"}, 32'(res_valid_o), 32'd1);
        check({tag, " res_lat"}, cyc - s, exp_lat);
        check({tag, " data"}, res_data_o, exp_data);
        check({tag, " err"}, 32'(res_err_o), 32'(exp_err));
        check({tag, " a_hold"}, a_o, a);
        check({tag, " b_hold"}, b_o, b);
        repeat (2) begin
            tick();
            check({tag, " valid_held"}, 32'(res_valid_o), 32'd1);
            check({tag, " data_held"}, res_data_o, exp_data);
            check({tag, " err_held"}, 32'(res_err_o), 32'(exp_err));
        end
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check({tag, " accepted"}, 32'(res_valid_o), 32'd0);
    endtask

    vec_t        vecs [8];
    logic [31:0] bb_a [5];
    logic [31:0] bb_b [5];
    logic [31:0] bb_r [5];

    initial begin
        int n;
        int seen;
        logic [31:0] ra;
        logic [31:0] rb;
        int rd;

        vecs[0] = '{32'd48,  32'd18, 10, 32'd6,  1'b0};
        vecs[1] = '{32'd7,   32'd0,  0,  32'd7,  1'b0};
        vecs[2] = '{32'd0,   32'd9,  1,  32'd9,  1'b0};
        vecs[3] = '{32'd17,  32'd5,  3,  32'd1,  1'b0};
        vecs[4] = '{32'd81,  32'd27, 15, 32'd27, 1'b0};
        vecs[5] = '{32'd100, 32'd75, 16, 32'd0,  1'b1};
        vecs[6] = '{32'd64,  32'd48, 19, 32'd0,  1'b1};
        vecs[7] = '{32'd35,  32'd21, 4,  32'd7,  1'b0};
        bb_a = '{32'd12, 32'd7, 32'd0, 32'd17, 32'd100};
        bb_b = '{32'd8,  32'd0, 32'd9, 32'd5,  32'd75};
        bb_r = '{32'd4,  32'd7, 32'd9, 32'd1,  32'd25};

        rst_i = 1'b1;
        in_valid_i = 1'b0;
        in_a_i = '0;
        in_b_i = '0;
        busy_i = 1'b0;
        res_ready_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check("rst start_o", 32'(start_o), 32'd0);
        check("rst a_o", a_o, 32'd0);
        check("rst b_o", b_o, 32'd0);
        check("rst res_valid", 32'(res_valid_o), 32'd0);
        check("rst res_data", res_data_o, 32'd0);
        check("rst res_err", 32'(res_err_o), 32'd0);
        check("rst pending", 32'(pending_o), 32'd0);
        check("rst in_ready", 32'(in_ready_o), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].a, vecs[i].b, vecs[i].delay, vecs[i].exp_data, vecs[i].exp_err,
                    $sformatf("vec%0d", i));
        end

        // Back-to-back with the consumer stalled: FIFO must fill to DEPTH.
        eng_delay = 2;
        for (int i = 0; i < 5; i++) begin
            in_a_i = bb_a[i];
            in_b_i = bb_b[i];
            in_valid_i = 1'b1;
            n = 0;
            while (!in_ready_o && n < 50) begin
                tick();
                n++;
            end
            tick();
        end
        check("bb pending_full", 32'(pending_o), 32'd4);
        check("bb in_ready_low", 32'(in_ready_o), 32'd0);
        in_a_i = 32'd1;
        in_b_i = 32'd1;
        repeat (3) tick();
        in_valid_i = 1'b0;
        check("bb no_overfill", 32'(pending_o), 32'd4);
        res_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!res_valid_o && n < 50) begin
                tick();
                n++;
            end
            check($sformatf("bb res%0d valid", i), 32'(res_valid_o), 32'd1);
            check($sformatf("bb res%0d data", i), res_data_o, bb_r[i]);
            tick();
        end
        res_ready_i = 1'b0;
        check("bb drained", 32'(pending_o), 32'd0);

        // Engine busy while the job waits in ISSUE.
        busy_i = 1'b1;
        eng_delay = 1;
        in_a_i = 32'd30;
        in_b_i = 32'd12;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        for (int k = 0; k < 20; k++) begin
            check("busy no_start", 32'(start_o), 32'd0);
            check("busy a_stable", a_o, 32'd30);
            check("busy b_stable", b_o, 32'd12);
            tick();
        end
        busy_i = 1'b0;
        tick();
        check("busy start_fires", 32'(start_o), 32'd1);
        tick();
        check("busy start_pulse", 32'(start_o), 32'd0);
        n = 0;
        while (!res_valid_o && n < 20) begin
            tick();
            n++;
        end
        check("busy res_data", res_data_o, 32'd6);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;

        // Randomized jobs against the timeout rule and a plain gcd.
        for (int i = 0; i < 25; i++) begin
            ra = $urandom_range(0, 500);
            rb = $urandom_range(0, 500);
            rd = $urandom_range(0, 19);
            run_job(ra, rb, rd, (rd <= TO - 1) ? ref_gcd(ra, rb) : 32'd0,
                    (rd > TO - 1), $sformatf("rnd%0d", i));
        end

        // Reset while a job is in WAIT and another is queued.
        eng_mute = 1'b1;
        in_a_i = 32'd9;
        in_b_i = 32'd6;
        in_valid_i = 1'b1;
        tick();
        in_a_i = 32'd8;
        in_b_i = 32'd4;
        tick();
        in_valid_i = 1'b0;
        n = 0;
        while (!start_o && n < 20) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("midrst pending_before", 32'(pending_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("midrst start_o", 32'(start_o), 32'd0);
        check("midrst a_o", a_o, 32'd0);
        check("midrst b_o", b_o, 32'd0);
        check("midrst res_valid", 32'(res_valid_o), 32'd0);
        check("midrst res_data", res_data_o, 32'd0);
        check("midrst res_err", 32'(res_err_o), 32'd0);
        check("midrst pending", 32'(pending_o), 32'd0);
        check("midrst in_ready", 32'(in_ready_o), 32'd1);
        tick();
        rst_i = 1'b0;
        eng_mute = 1'b0;
        res_ready_i = 1'b1;
        seen = 0;
        repeat (30) begin
            tick();
            if (res_valid_o || start_o) seen++;
        end
        check("midrst no_activity", seen, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
